// File: rtl/replay_run_ctrl_pkg.sv
// Shared types and helpers for the replay run controller.
// The FSM state encoding, index-width helper and timeout status code live here.
package replay_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int STATUS_TIMEOUT = 0;

    // Index width that never collapses to zero bits for a single channel.
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/replay_run_ctrl_if.sv
// Control/result bundle between a replay harness (master) and the run controller (slave).
interface replay_run_ctrl_if
    import replay_pkg::*;
#(
    parameter int CYCLE_W = 64,
    parameter int N_CHAN  = 4,
    parameter int CODE_W  = 8
);
    localparam int IDX_W = clog2_min1(N_CHAN);

    logic                     start;
    logic [CYCLE_W-1:0]       max_cycles;
    logic [CYCLE_W-1:0]       wave_start;
    logic [CYCLE_W-1:0]       wave_end;
    logic [N_CHAN-1:0]        exit_req;
    logic [N_CHAN*CODE_W-1:0] exit_code;
    logic                     done_ack;

    logic                     dut_reset;
    logic [CYCLE_W-1:0]       cycles;
    logic                     wave_en;
    logic                     busy;
    logic                     done;
    logic                     timed_out;
    logic [IDX_W-1:0]         exit_chan;
    logic [CODE_W-1:0]        status;

    modport master (
        output start, max_cycles, wave_start, wave_end, exit_req, exit_code, done_ack,
        input  dut_reset, cycles, wave_en, busy, done, timed_out, exit_chan, status
    );

    modport slave (
        input  start, max_cycles, wave_start, wave_end, exit_req, exit_code, done_ack,
        output dut_reset, cycles, wave_en, busy, done, timed_out, exit_chan, status
    );

endinterface

// File: rtl/replay_exit_arb.sv
// Fixed-priority exit arbiter: the lowest-index asserted request wins and its code is selected.
module replay_exit_arb #(
    parameter int N_CHAN = 4,
    parameter int CODE_W = 8,
    parameter int IDX_W  = 2
) (
    input  logic [N_CHAN-1:0]        req,
    input  logic [N_CHAN*CODE_W-1:0] codes,
    output logic                     any,
    output logic [IDX_W-1:0]         idx,
    output logic [CODE_W-1:0]        code
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        any  = |req;
        idx  = '0;
        code = '0;
        // Scanning downward lets the lowest asserted index overwrite the others.
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx  = IDX_W'(i);
                code = codes[i*CODE_W +: CODE_W];
            end
        end
    end

endmodule

// File: rtl/replay_run_ctrl.sv
// Run controller for replay/co-simulation: DUT reset sequencing, cycle counting,
// waveform window gating, exit/timeout arbitration, drain and done handshake.
module replay_run_ctrl
    import replay_pkg::*;
#(
    parameter int CYCLE_W      = 64,
    parameter int N_CHAN       = 4,
    parameter int CODE_W       = 8,
    parameter int RESET_CYCLES = 5,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic           clock,
    input  logic           reset,
    replay_run_ctrl_if.slave bus
);

    localparam int IDX_W   = clog2_min1(N_CHAN);
    localparam int CNT_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
    localparam int CNT_W   = clog2_min1(CNT_MAX);

    localparam logic [CYCLE_W-1:0] CYC_MAX    = '1;
    localparam logic [CNT_W-1:0]   RST_LOAD   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DRAIN_LOAD = CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [CYCLE_W-1:0] cycles_q, cycles_d, cycles_inc;
    logic [CYCLE_W-1:0] max_q, wave_start_q, wave_end_q;
    logic               term, limit_hit;

    logic               arb_any;
    logic [IDX_W-1:0]   arb_idx;
    logic [CODE_W-1:0]  arb_code;

    replay_exit_arb #(
        .N_CHAN (N_CHAN),
        .CODE_W (CODE_W),
        .IDX_W  (IDX_W)
    ) u_arb (
        .req   (bus.exit_req),
        .codes (bus.exit_code),
        .any   (arb_any),
        .idx   (arb_idx),
        .code  (arb_code)
    );

    assign cycles_inc = (cycles_q == CYC_MAX) ? cycles_q : cycles_q + 1'b1;
    // Reaching all-ones ends the run the same way as hitting a programmed limit.
    assign limit_hit  = (cycles_inc == CYC_MAX) ||
                        ((max_q != '0) && (cycles_inc == max_q));

    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        cycles_d = cycles_q;
        term     = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_d  = RST;
                    cnt_d    = RST_LOAD;
                    cycles_d = '0;
                end
            end
            RST: begin
                if (cnt == '0) state_d = RUN;
                else           cnt_d   = cnt - 1'b1;
            end
            RUN: begin
                cycles_d = cycles_inc;
                if (arb_any || limit_hit) begin
                    term = 1'b1;
                    if (DRAIN_CYCLES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                if (cnt == '0) state_d = DONE;
                else           cnt_d   = cnt - 1'b1;
            end
            DONE: begin
                if (bus.done_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.cycles = cycles_q;

    // Outputs are derived from the next state so they line up with it after the edge.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            cycles_q      <= '0;
            max_q         <= '0;
            wave_start_q  <= '0;
            wave_end_q    <= '0;
            bus.dut_reset <= 1'b1;
            bus.wave_en   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.timed_out <= 1'b0;
            bus.exit_chan <= '0;
            bus.status    <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            cycles_q <= cycles_d;

            bus.dut_reset <= !((state_d == RUN) || (state_d == DRAIN));
            bus.busy      <= (state_d != IDLE);
            bus.done      <= (state_d == DONE);
            bus.wave_en   <= ((state_d == RUN) || (state_d == DRAIN)) &&
                             (wave_start_q <= cycles_d) && (cycles_d < wave_end_q);

            if (state == IDLE && bus.start) begin
                max_q         <= bus.max_cycles;
                wave_start_q  <= bus.wave_start;
                wave_end_q    <= bus.wave_end;
                bus.timed_out <= 1'b0;
                bus.exit_chan <= '0;
                bus.status    <= '0;
            end

            if (term) begin
                if (arb_any) begin
                    bus.timed_out <= 1'b0;
                    bus.exit_chan <= arb_idx;
                    bus.status    <= arb_code;
                end else begin
                    bus.timed_out <= 1'b1;
                    bus.exit_chan <= '0;
                    bus.status    <= CODE_W'(STATUS_TIMEOUT);
                end
            end
        end
    end

endmodule

// File: tb/tb_replay_run_ctrl.sv
// Directed bench for replay_run_ctrl: exit, timeout, priority, wave window, reset, handshake, saturation.
module tb_replay_run_ctrl;

    logic clock;
    logic reset;

    replay_run_ctrl_if #(.CYCLE_W(64), .N_CHAN(4), .CODE_W(8)) mi ();
    replay_run_ctrl_if #(.CYCLE_W(8),  .N_CHAN(4), .CODE_W(8)) si ();

    replay_run_ctrl #(
        .CYCLE_W(64), .N_CHAN(4), .CODE_W(8), .RESET_CYCLES(5), .DRAIN_CYCLES(2)
    ) u_main (
        .clock (clock),
        .reset (reset),
        .bus   (mi)
    );

    replay_run_ctrl #(
        .CYCLE_W(8), .N_CHAN(4), .CODE_W(8), .RESET_CYCLES(5), .DRAIN_CYCLES(2)
    ) u_sat (
        .clock (clock),
        .reset (reset),
        .bus   (si)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ack_main();
        mi.done_ack = 1'b1;
        tick();
        mi.done_ack = 1'b0;
    endtask

    initial begin
        int n;
        int wave_n;
        int wave_first;
        int wave_last;
        int drain_n;

        reset = 1'b1;
        mi.start = 0; mi.max_cycles = 0; mi.wave_start = 0; mi.wave_end = 0;
        mi.exit_req = 0; mi.exit_code = 0; mi.done_ack = 0;
        si.start = 0; si.max_cycles = 0; si.wave_start = 0; si.wave_end = 0;
        si.exit_req = 0; si.exit_code = 0; si.done_ack = 0;
        tick();
        tick();

        check("rst_dut_reset", mi.dut_reset, 1);
        check("rst_busy",      mi.busy, 0);
        check("rst_done",      mi.done, 0);
        check("rst_cycles",    mi.cycles, 0);
        check("rst_wave_en",   mi.wave_en, 0);
        check("rst_timed_out", mi.timed_out, 0);
        check("rst_exit_chan", mi.exit_chan, 0);
        check("rst_status",    mi.status, 0);
        check("rst_sat_dut_reset", si.dut_reset, 1);
        reset = 1'b0;
        tick();

        // Plain exit on channel 2 at cycles=100, wave window 10..19.
        mi.max_cycles = 0; mi.wave_start = 10; mi.wave_end = 20;
        mi.exit_code = {8'h44, 8'h5A, 8'h22, 8'h11};
        mi.start = 1;
        tick();
        mi.start = 0;
        check("t1_busy_after_start", mi.busy, 1);
        n = 0;
        while (mi.dut_reset && n < 20) begin
            n++;
            tick();
        end
        check("t1_reset_len", n, 5);
        check("t1_first_run_cycles", mi.cycles, 0);
        wave_n = 0; wave_first = -1; wave_last = -1;
        n = 0;
        while (mi.cycles != 100 && n < 300) begin
            if (mi.wave_en) begin
                wave_n++;
                if (wave_first < 0) wave_first = int'(mi.cycles);
                wave_last = int'(mi.cycles);
            end
            tick();
            n++;
        end
        check("t1_reach_100", mi.cycles, 100);
        check("t1_wave_count", wave_n, 10);
        check("t1_wave_first", wave_first, 10);
        check("t1_wave_last",  wave_last, 19);
        mi.exit_req = 4'b0100;
        tick();
        mi.exit_req = 4'b0001;
        check("t1_term_cycles",   mi.cycles, 101);
        check("t1_drain_dut_rst", mi.dut_reset, 0);
        check("t1_drain_done",    mi.done, 0);
        tick();
        check("t1_drain2_done", mi.done, 0);
        check("t1_drain2_cycles", mi.cycles, 101);
        tick();
        mi.exit_req = 0;
        check("t1_done",      mi.done, 1);
        check("t1_exit_chan", mi.exit_chan, 2);
        check("t1_status",    mi.status, 8'h5A);
        check("t1_timed_out", mi.timed_out, 0);
        check("t1_cycles",    mi.cycles, 101);
        check("t1_done_dut_reset", mi.dut_reset, 1);
        check("t1_done_wave_en",   mi.wave_en, 0);

        // Handshake: done holds while done_ack is low; start during DONE is ignored.
        for (int i = 0; i < 8; i++) begin
            mi.start = (i == 3);
            tick();
            check("hs_done_hold",   mi.done, 1);
            check("hs_status_hold", mi.status, 8'h5A);
        end
        mi.start = 0;
        check("hs_cycles_hold", mi.cycles, 101);
        ack_main();
        check("hs_done_clear", mi.done, 0);
        check("hs_busy_clear", mi.busy, 0);
        check("hs_dut_reset",  mi.dut_reset, 1);
        check("hs_cycles_kept", mi.cycles, 101);

        // Exit 4'b1010 arrives on the same cycle the limit of 50 is reached.
        mi.max_cycles = 50; mi.wave_start = 0; mi.wave_end = 0;
        mi.exit_code = {8'h44, 8'h33, 8'h22, 8'h11};
        mi.start = 1;
        tick();
        mi.start = 0;
        check("t3_clear_cycles", mi.cycles, 0);
        check("t3_clear_chan",   mi.exit_chan, 0);
        check("t3_clear_status", mi.status, 0);
        n = 0;
        while (mi.cycles != 49 && n < 200) begin
            tick();
            n++;
        end
        check("t3_reach_49", mi.cycles, 49);
        mi.exit_req = 4'b1010;
        tick();
        mi.exit_req = 0;
        check("t3_term_cycles", mi.cycles, 50);
        n = 0;
        while (!mi.done && n < 20) begin
            tick();
            n++;
        end
        check("t3_done",      mi.done, 1);
        check("t3_exit_chan", mi.exit_chan, 1);
        check("t3_timed_out", mi.timed_out, 0);
        check("t3_status",    mi.status, 8'h22);
        ack_main();

        // Pure timeout at 50 with an empty (inverted) wave window.
        mi.max_cycles = 50; mi.wave_start = 30; mi.wave_end = 20;
        mi.start = 1;
        tick();
        mi.start = 0;
        wave_n = 0; drain_n = 0;
        n = 0;
        while (!mi.done && n < 200) begin
            if (mi.wave_en) wave_n++;
            if (mi.busy && !mi.dut_reset && mi.cycles == 50) drain_n++;
            tick();
            n++;
        end
        check("t2_done",      mi.done, 1);
        check("t2_timed_out", mi.timed_out, 1);
        check("t2_status",    mi.status, 0);
        check("t2_exit_chan", mi.exit_chan, 0);
        check("t2_cycles",    mi.cycles, 50);
        check("t2_drain_len", drain_n, 2);
        check("t2_wave_never", wave_n, 0);
        ack_main();

        // Block reset mid-run, then a fresh run to a limit of 20.
        mi.max_cycles = 0; mi.wave_start = 0; mi.wave_end = 0;
        mi.start = 1;
        tick();
        mi.start = 0;
        n = 0;
        while (mi.cycles != 37 && n < 200) begin
            tick();
            n++;
        end
        check("t4_reach_37", mi.cycles, 37);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t4_busy",      mi.busy, 0);
        check("t4_cycles",    mi.cycles, 0);
        check("t4_dut_reset", mi.dut_reset, 1);
        check("t4_done",      mi.done, 0);
        mi.max_cycles = 20;
        mi.start = 1;
        tick();
        mi.start = 0;
        n = 0;
        while (!mi.done && n < 100) begin
            tick();
            n++;
        end
        check("t4_rerun_done",      mi.done, 1);
        check("t4_rerun_cycles",    mi.cycles, 20);
        check("t4_rerun_timed_out", mi.timed_out, 1);
        ack_main();

        // 8-bit counter with no limit saturates at 255 and times out.
        si.start = 1;
        tick();
        si.start = 0;
        n = 0;
        while (!si.done && n < 400) begin
            tick();
            n++;
        end
        check("t5_done",      si.done, 1);
        check("t5_cycles",    si.cycles, 255);
        check("t5_timed_out", si.timed_out, 1);
        check("t5_status",    si.status, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/replay_run_ctrl.md
Name: replay_run_ctrl

Overview:
- Synthesizable run controller for replay/co-simulation harnesses, parametrised in counter width and exit channel count.
- Sequences a run: holds DUT reset for a fixed number of cycles, then counts DUT cycles.
- Gates a waveform-capture window and arbitrates multiple exit sources plus a cycle-limit timeout.
- Drains a fixed number of cycles after termination, then reports done/status through a handshake.

Parameters:
- CYCLE_W, 64: width of cycle counter and cycle-valued inputs.
- N_CHAN, 4: number of exit request channels (1..16).
- CODE_W, 8: width of per-channel exit code.
- RESET_CYCLES, 5: cycles dut_reset is held high after start (>=1).
- DRAIN_CYCLES, 2: cycles spent in DRAIN after termination (>=0).

Ports:
- clock, input, 1: sole clock.
- reset, input, 1: synchronous, active-high block reset.
- start, input, 1: begin run; sampled in IDLE only.
- max_cycles, input, CYCLE_W: cycle limit; 0 = unlimited; latched on start.
- wave_start, input, CYCLE_W: first cycle count with wave_en high; latched on start.
- wave_end, input, CYCLE_W: first cycle count with wave_en low (exclusive); latched on start.
- exit_req, input, N_CHAN: per-channel exit request; level, sampled in RUN.
- exit_code, input, N_CHAN*CODE_W: channel i code in bits [i*CODE_W +: CODE_W].
- done_ack, input, 1: consumer acknowledges done.
- dut_reset, output, 1: reset driven to the DUT.
- cycles, output, CYCLE_W: DUT cycles elapsed since reset release.
- wave_en, output, 1: waveform capture enable.
- busy, output, 1: state is not IDLE.
- done, output, 1: result valid.
- timed_out, output, 1: run ended by max_cycles.
- exit_chan, output, $clog2(N_CHAN) (min 1): winning channel.
- status, output, CODE_W: winning exit code; 0 on timeout.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, cycles = 0.
  - dut_reset = 1, wave_en = 0, busy = 0, done = 0, timed_out = 0, exit_chan = 0, status = 0.
  - reset overrides everything, mid-run included.
- All outputs are registered.
- IDLE:
  - dut_reset = 1.
  - On start: latch max_cycles/wave_start/wave_end, clear cycles and result fields, go to RST.
- RST:
  - dut_reset = 1 for exactly RESET_CYCLES cycles (down-counter), then go to RUN.
  - dut_reset falls on the first RUN cycle.
- RUN:
  - cycles increments by 1 each RUN cycle.
  - Saturates at all-ones; saturation forces timeout.
- RUN termination:
  - If any exit_req bit is set, the lowest index wins: latch exit_chan = index, status = that code, timed_out = 0.
  - Else if max_cycles != 0 and cycles+1 == max_cycles (the increment that reaches the limit): timed_out = 1, status = 0, exit_chan = 0.
  - Exit beats timeout in the same cycle.
  - On termination go to DRAIN; if DRAIN_CYCLES = 0, go directly to DONE.
- DRAIN:
  - Counter holds; dut_reset = 0.
  - exit_req is ignored.
  - Lasts DRAIN_CYCLES cycles, then DONE.
- DONE:
  - done = 1 and dut_reset = 1.
  - Result fields stay stable until done_ack.
  - done_ack while done = 1: next cycle done = 0, state = IDLE.
  - cycles keeps its final value until the next start.
- Waveform window:
  - wave_en is registered and equals: (state in RUN or DRAIN) and wave_start <= next cycles value < wave_end.
  - wave_start >= wave_end means wave_en stays 0.
  - wave_en = 0 in IDLE, RST and DONE.
- Ignored inputs:
  - start outside IDLE is ignored.
  - done_ack outside DONE is ignored.
- Arithmetic: all compares unsigned, CYCLE_W wide; no wrap (saturate).

Decomposition:
- replay_pkg holds:
  - state enum {IDLE, RST, RUN, DRAIN, DONE};
  - function clog2_min1;
  - STATUS_TIMEOUT = 0 constant.
- One sub-module, replay_exit_arb: fixed-priority (lowest index) encoder plus code mux over N_CHAN channels, outputs any/idx/code. It is purely combinational and instantiated once.

Test Plan:
- Plain exit, max_cycles=0, RESET_CYCLES=5: start at t0; exit_req[2]=1 with code 0x5A at cycles=100.
  Required: dut_reset high exactly 5 cycles after start; done with exit_chan=2, status=0x5A, timed_out=0, cycles=101.
- Timeout, max_cycles=50, no exit: required timed_out=1, status=0, cycles=50, DRAIN lasts 2 cycles before done.
- Simultaneous requests: exit_req=4'b1010 in the same cycle the limit is reached.
  Required: exit_chan=1, timed_out=0.
- Waveform window, wave_start=10, wave_end=20: wave_en high for exactly the cycles where cycles = 10..19 (10 cycles).
  With wave_start=30, wave_end=20: wave_en never high.
- Reset mid-RUN at cycles=37: next cycle state IDLE, cycles=0, dut_reset=1, done=0.
  A new start then runs normally.
- Handshake: hold done_ack low 8 cycles, so done and status stay stable; pulse done_ack, so done=0 the next cycle.
  start asserted during DONE is ignored.
- Saturation, CYCLE_W=8, max_cycles=0: counter stops at 255, timed_out=1.
